// File: rtl/tcp_tx_arb.sv
// tcp_tx_arb: round-robin arbiter merging N_SRC byte streams into the SiTCP TX FIFO.
// Optional: define TCP_ARB_HEADER_EN to prefix every grant with header byte {5'b10100, grant_id}.
module tcp_tx_arb #(
    parameter int N_SRC     = 4,
    parameter int MAX_BURST = 256
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               tcp_open_ack,
    input  logic               tcp_tx_full,
    output logic               tcp_tx_wr,
    output logic [7:0]         tcp_txd,
    input  logic [N_SRC-1:0]   src_valid,
    input  logic [8*N_SRC-1:0] src_data,
    input  logic [N_SRC-1:0]   src_last,
    output logic [N_SRC-1:0]   src_ready,
    output logic [2:0]         grant_id,
    output logic               busy
);

    localparam logic [1:0]  ST_IDLE     = 2'd0;
    localparam logic [1:0]  ST_DATA     = 2'd2;
`ifdef TCP_ARB_HEADER_EN
    localparam logic [1:0]  ST_HDR      = 2'd1;
    localparam logic [4:0]  HDR_TAG     = 5'b10100;
`endif
    localparam logic [12:0] BURST_LIMIT = 13'(MAX_BURST);
    localparam logic [2:0]  LAST_INIT   = 3'(N_SRC - 1);

    logic [1:0]  state;
    logic [2:0]  last_grant;
    logic [12:0] byte_cnt;
    logic [12:0] cnt_next;
    logic        req_found;
    logic [2:0]  req_sel;
    logic        cur_valid;
    logic        cur_last;
    logic [7:0]  cur_data;
    logic        can_send;
    logic        xfer;

    // Round-robin search starting just after the source that finished last.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        req_found = 1'b0;
        req_sel   = 3'd0;
        for (int i = 1; i <= N_SRC; i++) begin
            idx = (int'(last_grant) + i) % N_SRC;
            if (!req_found && src_valid[idx]) begin
                req_found = 1'b1;
                req_sel   = 3'(idx);
            end
        end
    end

    always_comb begin
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        cur_data  = 8'h00;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant_id == 3'(i)) begin
                cur_valid = src_valid[i];
                cur_last  = src_last[i];
                cur_data  = src_data[8*i +: 8];
            end
        end
    end

    assign can_send = (state == ST_DATA) && tcp_open_ack && !tcp_tx_full;
    assign xfer     = can_send && cur_valid;
    assign cnt_next = byte_cnt + 13'd1;
    assign busy     = (state != ST_IDLE);

    always_comb begin
        src_ready = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (can_send && (grant_id == 3'(i))) begin
                src_ready[i] = 1'b1;
            end
        end
    end

    // A dropped connection abandons the grant without touching last_grant,
    // so the interrupted source is simply re-arbitrated later.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= ST_IDLE;
            last_grant <= LAST_INIT;
            byte_cnt   <= 13'd0;
            grant_id   <= 3'd0;
            tcp_tx_wr  <= 1'b0;
            tcp_txd    <= 8'h00;
        end else begin
            tcp_tx_wr <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tcp_open_ack && req_found) begin
                        grant_id <= req_sel;
                        byte_cnt <= 13'd0;
`ifdef TCP_ARB_HEADER_EN
                        state    <= ST_HDR;
`else
                        state    <= ST_DATA;
`endif
                    end
                end
`ifdef TCP_ARB_HEADER_EN
                ST_HDR: begin
                    if (!tcp_open_ack) begin
                        state <= ST_IDLE;
                    end else if (!tcp_tx_full) begin
                        tcp_tx_wr <= 1'b1;
                        tcp_txd   <= {HDR_TAG, grant_id};
                        state     <= ST_DATA;
                    end
                end
`endif
                ST_DATA: begin
                    if (!tcp_open_ack) begin
                        state <= ST_IDLE;
                    end else if (xfer) begin
                        tcp_tx_wr <= 1'b1;
                        tcp_txd   <= cur_data;
                        byte_cnt  <= cnt_next;
                        if (cur_last || (cnt_next == BURST_LIMIT)) begin
                            state      <= ST_IDLE;
                            last_grant <= grant_id;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tcp_tx_arb.sv
// tb_tcp_tx_arb: directed self-checking bench for tcp_tx_arb (N_SRC=4, MAX_BURST=4).
// Expectations adapt to TCP_ARB_HEADER_EN so the bench works with or without the header byte.
`timescale 1ns/1ps
module tb_tcp_tx_arb;

    localparam int N_SRC     = 4;
    localparam int MAX_BURST = 4;
`ifdef TCP_ARB_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic               sys_clk;
    logic               sys_rst;
    logic               tcp_open_ack;
    logic               tcp_tx_full;
    logic               tcp_tx_wr;
    logic [7:0]         tcp_txd;
    logic [N_SRC-1:0]   src_valid;
    logic [8*N_SRC-1:0] src_data;
    logic [N_SRC-1:0]   src_last;
    logic [N_SRC-1:0]   src_ready;
    logic [2:0]         grant_id;
    logic               busy;

    tcp_tx_arb #(.N_SRC(N_SRC), .MAX_BURST(MAX_BURST)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .tcp_open_ack(tcp_open_ack),
        .tcp_tx_full (tcp_tx_full),
        .tcp_tx_wr   (tcp_tx_wr),
        .tcp_txd     (tcp_txd),
        .src_valid   (src_valid),
        .src_data    (src_data),
        .src_last    (src_last),
        .src_ready   (src_ready),
        .grant_id    (grant_id),
        .busy        (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Per-source byte queues: {last, data}
    logic [8:0] src_mem [N_SRC][32];
    int         head [N_SRC];
    int         tail [N_SRC];

    logic [7:0] wr_data [$];
    logic [2:0] wr_gid  [$];
    int         wr_call [$];
    logic [7:0] exp_d   [$];
    logic [2:0] exp_g   [$];

    int               call_no;
    logic [N_SRC-1:0] obs_ready;
    logic             obs_wr;
    int               checks;
    int               errors;

    task automatic push(input int s, input logic [7:0] d, input logic l);
        src_mem[s][tail[s]] = {l, d};
        tail[s]++;
    endtask

    task automatic clear_logs();
        wr_data.delete();
        wr_gid.delete();
        wr_call.delete();
        exp_d.delete();
        exp_g.delete();
    endtask

    task automatic expect_byte(input logic [7:0] d, input logic [2:0] g);
        exp_d.push_back(d);
        exp_g.push_back(g);
    endtask

    task automatic expect_hdr(input logic [2:0] g);
        if (HDR != 0) begin
            exp_d.push_back({5'b10100, g});
            exp_g.push_back(g);
        end
    endtask

    // Empty sources drive last=1 with valid=0, which must be ignored.
    task automatic drive_src();
        for (int i = 0; i < N_SRC; i++) begin
            if (head[i] != tail[i]) begin
                src_valid[i]        = 1'b1;
                src_data[8*i +: 8]  = src_mem[i][head[i]][7:0];
                src_last[i]         = src_mem[i][head[i]][8];
            end else begin
                src_valid[i]        = 1'b0;
                src_data[8*i +: 8]  = 8'hEE;
                src_last[i]         = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        logic [N_SRC-1:0] fire;
        drive_src();
        #1;
        obs_ready = src_ready;
        fire = sys_rst ? '0 : (src_valid & src_ready);
        @(posedge sys_clk);
        @(negedge sys_clk);
        for (int i = 0; i < N_SRC; i++) begin
            if (fire[i]) head[i]++;
        end
        obs_wr = tcp_tx_wr;
        if (tcp_tx_wr) begin
            wr_data.push_back(tcp_txd);
            wr_gid.push_back(grant_id);
            wr_call.push_back(call_no);
        end
        call_no++;
    endtask

    task automatic run_until(input int n, input int budget, input string name);
        int b;
        b = 0;
        while (wr_data.size() < n && b < budget) begin
            cycle();
            b++;
        end
        checks++;
        if (wr_data.size() < n) begin
            errors++;
            $display("[TB] FAIL %s timeout: writes=%0d required=%0d", name, wr_data.size(), n);
        end
    endtask

    task automatic test_reset();
        sys_rst      = 1'b1;
        tcp_open_ack = 1'b0;
        tcp_tx_full  = 1'b0;
        cycle();
        cycle();
        checks++; if (tcp_tx_wr !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr: got %b expected 0", tcp_tx_wr); end
        checks++; if (tcp_txd !== 8'h00) begin errors++; $display("[TB] FAIL reset_txd: got %h expected 00", tcp_txd); end
        checks++; if (src_ready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0000", src_ready); end
        checks++; if (grant_id !== 3'd0) begin errors++; $display("[TB] FAIL reset_gid: got %0d expected 0", grant_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        sys_rst = 1'b0;
    endtask

    task automatic test_two_sources();
        clear_logs();
        tcp_open_ack = 1'b1;
        push(0, 8'h11, 1'b0); push(0, 8'h12, 1'b0); push(0, 8'h13, 1'b1);
        push(2, 8'h21, 1'b0); push(2, 8'h22, 1'b0); push(2, 8'h23, 1'b1);
        expect_hdr(3'd0); expect_byte(8'h11, 3'd0); expect_byte(8'h12, 3'd0); expect_byte(8'h13, 3'd0);
        expect_hdr(3'd2); expect_byte(8'h21, 3'd2); expect_byte(8'h22, 3'd2); expect_byte(8'h23, 3'd2);
        run_until(exp_d.size(), 40, "two_src");
        cycle(); cycle();
        checks++; if (wr_data.size() != exp_d.size()) begin errors++; $display("[TB] FAIL two_src_count: got %0d expected %0d", wr_data.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < wr_data.size(); i++) begin
            checks++;
            if (wr_data[i] !== exp_d[i] || wr_gid[i] !== exp_g[i]) begin
                errors++;
                $display("[TB] FAIL two_src_byte%0d: got %h/gid%0d expected %h/gid%0d", i, wr_data[i], wr_gid[i], exp_d[i], exp_g[i]);
            end
        end
        if (wr_call.size() > HDR + 3) begin
            checks++;
            if (wr_call[HDR+3] - wr_call[HDR+2] != 2) begin
                errors++;
                $display("[TB] FAIL two_src_gap: got %0d cycles expected 2", wr_call[HDR+3] - wr_call[HDR+2]);
            end
        end
    endtask

    task automatic test_max_burst();
        clear_logs();
        for (int i = 0; i < 10; i++) push(1, 8'h30 + 8'(i), 1'b0);
        push(3, 8'h40, 1'b0); push(3, 8'h41, 1'b1);
        push(3, 8'h42, 1'b0); push(3, 8'h43, 1'b1);
        push(3, 8'h44, 1'b0); push(3, 8'h45, 1'b1);
        expect_hdr(3'd3); expect_byte(8'h40, 3'd3); expect_byte(8'h41, 3'd3);
        expect_hdr(3'd1); for (int i = 0; i < 4; i++) expect_byte(8'h30 + 8'(i), 3'd1);
        expect_hdr(3'd3); expect_byte(8'h42, 3'd3); expect_byte(8'h43, 3'd3);
        expect_hdr(3'd1); for (int i = 4; i < 8; i++) expect_byte(8'h30 + 8'(i), 3'd1);
        expect_hdr(3'd3); expect_byte(8'h44, 3'd3); expect_byte(8'h45, 3'd3);
        expect_hdr(3'd1); expect_byte(8'h38, 3'd1); expect_byte(8'h39, 3'd1);
        run_until(exp_d.size(), 80, "burst");
        cycle(); cycle();
        checks++; if (wr_data.size() != exp_d.size()) begin errors++; $display("[TB] FAIL burst_count: got %0d expected %0d", wr_data.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < wr_data.size(); i++) begin
            checks++;
            if (wr_data[i] !== exp_d[i] || wr_gid[i] !== exp_g[i]) begin
                errors++;
                $display("[TB] FAIL burst_byte%0d: got %h/gid%0d expected %h/gid%0d", i, wr_data[i], wr_gid[i], exp_d[i], exp_g[i]);
            end
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL burst_held_busy: got %b expected 1", busy); end
        checks++; if (grant_id !== 3'd1) begin errors++; $display("[TB] FAIL burst_held_gid: got %0d expected 1", grant_id); end
        sys_rst = 1'b1;
        cycle();
        sys_rst = 1'b0;
    endtask

    task automatic test_tx_full();
        clear_logs();
        push(0, 8'h50, 1'b0); push(0, 8'h51, 1'b0); push(0, 8'h52, 1'b1);
        expect_hdr(3'd0); expect_byte(8'h50, 3'd0); expect_byte(8'h51, 3'd0); expect_byte(8'h52, 3'd0);
        run_until(HDR + 1, 20, "full_first");
        tcp_tx_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            checks++; if (obs_ready !== 4'b0000) begin errors++; $display("[TB] FAIL full_ready%0d: got %b expected 0000", k, obs_ready); end
            checks++; if (obs_wr !== 1'b0) begin errors++; $display("[TB] FAIL full_wr%0d: got %b expected 0", k, obs_wr); end
        end
        tcp_tx_full = 1'b0;
        run_until(exp_d.size(), 20, "full_rest");
        cycle(); cycle();
        checks++; if (wr_data.size() != exp_d.size()) begin errors++; $display("[TB] FAIL full_count: got %0d expected %0d", wr_data.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < wr_data.size(); i++) begin
            checks++;
            if (wr_data[i] !== exp_d[i] || wr_gid[i] !== exp_g[i]) begin
                errors++;
                $display("[TB] FAIL full_byte%0d: got %h/gid%0d expected %h/gid%0d", i, wr_data[i], wr_gid[i], exp_d[i], exp_g[i]);
            end
        end
    endtask

    task automatic test_open_ack_drop();
        clear_logs();
        for (int i = 0; i < 6; i++) push(1, 8'h60 + 8'(i), (i == 5));
        expect_hdr(3'd1); expect_byte(8'h60, 3'd1); expect_byte(8'h61, 3'd1);
        expect_hdr(3'd1);
        for (int i = 2; i < 6; i++) expect_byte(8'h60 + 8'(i), 3'd1);
        run_until(HDR + 2, 20, "drop_first");
        tcp_open_ack = 1'b0;
        cycle();
        checks++; if (obs_ready !== 4'b0000) begin errors++; $display("[TB] FAIL drop_ready: got %b expected 0000", obs_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL drop_idle: busy got %b expected 0", busy); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (obs_wr !== 1'b0) begin errors++; $display("[TB] FAIL drop_wr%0d: got %b expected 0", k, obs_wr); end
            cycle();
        end
        checks++; if (wr_data.size() != HDR + 2) begin errors++; $display("[TB] FAIL drop_count: got %0d expected %0d", wr_data.size(), HDR + 2); end
        tcp_open_ack = 1'b1;
        run_until(exp_d.size(), 30, "drop_resume");
        cycle(); cycle();
        checks++; if (wr_data.size() != exp_d.size()) begin errors++; $display("[TB] FAIL drop_total: got %0d expected %0d", wr_data.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < wr_data.size(); i++) begin
            checks++;
            if (wr_data[i] !== exp_d[i] || wr_gid[i] !== exp_g[i]) begin
                errors++;
                $display("[TB] FAIL drop_byte%0d: got %h/gid%0d expected %h/gid%0d", i, wr_data[i], wr_gid[i], exp_d[i], exp_g[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] first_exp;
        clear_logs();
        for (int i = 0; i < 6; i++) push(2, 8'h70 + 8'(i), 1'b0);
        push(0, 8'h80, 1'b0); push(0, 8'h81, 1'b1);
        run_until(HDR + 2, 20, "rst_first");
        first_exp = (HDR != 0) ? 8'hA2 : 8'h70;
        if (wr_data.size() > 0) begin
            checks++;
            if (wr_data[0] !== first_exp || wr_gid[0] !== 3'd2) begin
                errors++;
                $display("[TB] FAIL rst_first_byte: got %h/gid%0d expected %h/gid2", wr_data[0], wr_gid[0], first_exp);
            end
        end
        sys_rst = 1'b1;
        cycle();
        checks++; if (tcp_tx_wr !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_wr: got %b expected 0", tcp_tx_wr); end
        checks++; if (tcp_txd !== 8'h00) begin errors++; $display("[TB] FAIL rst_mid_txd: got %h expected 00", tcp_txd); end
        checks++; if (src_ready !== 4'b0000) begin errors++; $display("[TB] FAIL rst_mid_ready: got %b expected 0000", src_ready); end
        checks++; if (grant_id !== 3'd0) begin errors++; $display("[TB] FAIL rst_mid_gid: got %0d expected 0", grant_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_busy: got %b expected 0", busy); end
        sys_rst = 1'b0;
        clear_logs();
        cycle();
        checks++; if (obs_wr !== 1'b0) begin errors++; $display("[TB] FAIL rst_after_wr: got %b expected 0", obs_wr); end
        run_until(HDR + 2, 20, "rst_next");
        first_exp = (HDR != 0) ? 8'hA0 : 8'h80;
        if (wr_data.size() >= HDR + 2) begin
            checks++;
            if (wr_data[0] !== first_exp || wr_gid[0] !== 3'd0) begin
                errors++;
                $display("[TB] FAIL rst_next_first: got %h/gid%0d expected %h/gid0", wr_data[0], wr_gid[0], first_exp);
            end
            checks++;
            if (wr_data[HDR+1] !== 8'h81) begin
                errors++;
                $display("[TB] FAIL rst_next_second: got %h expected 81", wr_data[HDR+1]);
            end
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        call_no      = 0;
        obs_ready    = '0;
        obs_wr       = 1'b0;
        sys_rst      = 1'b1;
        tcp_open_ack = 1'b0;
        tcp_tx_full  = 1'b0;
        src_valid    = '0;
        src_data     = '0;
        src_last     = '0;
        for (int i = 0; i < N_SRC; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        test_reset();
        test_two_sources();
        test_max_burst();
        test_tx_full();
        test_open_ack_drop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
